neureka_streamer_sequencer: RTL and testbench
=============================================

Name: neureka_streamer_sequencer

Overview:
Phase sequencer for the NEUREKA streamer load/store datapath.
- Takes one job descriptor and walks the shared TCDM path through an ordered list of phases: FEAT, WEIGHT (repeated), NORM, STREAMIN, STORE.
- For each phase it drives the load-select code, the load/store mux select, source/sink start pulses and clear pulses.
- It changes the mux select only once the selected source/sink reports done and the TCDM FIFO has drained.
- It sits between the NEUREKA controller FSM and the streamer control inputs.

Parameters:
WEIGHT_CNT_W, 8, width of weight-phase repeat count
CNT_W, 32, width of optional performance counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear, returns to IDLE
start_i  in  1  job start pulse, sampled in IDLE only
en_feat_i  in  1  job includes FEAT load
en_weight_i  in  1  job includes WEIGHT loads
n_weight_i  in  WEIGHT_CNT_W  number of WEIGHT loads (0 treated as 1)
en_norm_i  in  1  job includes NORM load
en_streamin_i  in  1  job includes STREAMIN load
en_store_i  in  1  job includes STORE phase
source_done_i  in  1  done pulse/level from active source
sink_done_i  in  1  done pulse/level from sink
fifo_empty_i  in  1  TCDM FIFO empty flag
ld_which_sel_o  out  3  0 FEAT, 1 WEIGHT, 3 NORM, 4 STREAMIN
ld_st_sel_o  out  1  0 load path, 1 store path
src_req_start_o  out  1  one-cycle source start pulse
sink_req_start_o  out  1  one-cycle sink start pulse
clear_source_o  out  1  one-cycle source clear between phases
clear_sink_o  out  1  one-cycle sink clear after store
busy_o  out  1  job in progress
done_o  out  1  one-cycle job-complete pulse
perf_busy_cnt_o  out  CNT_W  busy-cycle counter (optional feature)
perf_drain_cnt_o  out  CNT_W  drain-stall counter (optional feature)

Behaviour:
Reset and clear:
- Reset values: ld_which_sel_o=0, ld_st_sel_o=0, busy_o=0, all pulse outputs 0, counters 0. The internal state is IDLE.
- clear_i has priority over every transition. It forces IDLE and reset output values in the next cycle. The latched job is discarded.
- Reset asserted mid-job has the same effect asynchronously.

Job acceptance:
- IDLE accepts start_i. It latches all en_*_i and n_weight_i, and sets the weight counter to max(n_weight_i,1).
- start_i is ignored while busy_o=1.
- busy_o=1 from the cycle after start is accepted through the done_o cycle.

States:
- IDLE -> SELECT on start_i.
- SELECT picks the first enabled remaining phase in the order FEAT, WEIGHT, NORM, STREAMIN, STORE. With none remaining it goes to FINISH. It updates ld_which_sel_o/ld_st_sel_o in this cycle. Each SELECT costs exactly 1 cycle.
- L_ISSUE: src_req_start_o=1 for exactly 1 cycle -> L_WAIT.
- L_WAIT: waits for source_done_i=1 -> L_DRAIN. source_done_i in the L_ISSUE cycle is stale and ignored.
- L_DRAIN: waits for fifo_empty_i=1. Then clear_source_o=1 for 1 cycle.
  - In a WEIGHT phase it decrements the weight counter. If the counter is nonzero it goes to L_ISSUE again, with no SELECT and sel unchanged.
  - Otherwise it marks the phase complete -> SELECT.
- S_ISSUE: ld_st_sel_o=1, sink_req_start_o=1 for 1 cycle -> S_WAIT.
- S_WAIT: waits for sink_done_i -> S_DRAIN.
- S_DRAIN: waits for fifo_empty_i. Then clear_sink_o=1 for 1 cycle -> SELECT.
- FINISH: done_o=1 for 1 cycle, ld_st_sel_o=0, ld_which_sel_o=0 -> IDLE.

Latency and boundary rules:
- Minimum per load phase (done and empty already high): SELECT 1 + ISSUE 1 + WAIT 1 + DRAIN 1 = 4 cycles.
- An empty job (all enables 0): done_o rises 2 cycles after start_i (IDLE->SELECT->FINISH).
- ld_which_sel_o and ld_st_sel_o are stable from SELECT through the end of the phase's DRAIN. They never change while fifo_empty_i=0.
- The weight counter saturates at 0. n_weight_i at its maximum value gives exactly 2^WEIGHT_CNT_W-1 loads.
- If done and empty are both high in the WAIT cycle, WAIT still advances to DRAIN first, with no skipping.

Optional Feature:
NEUREKA_STREAMER_SEQ_PERF_EN
- Defined:
  - perf_busy_cnt_o increments every cycle busy_o=1.
  - perf_drain_cnt_o increments every L_DRAIN/S_DRAIN cycle with fifo_empty_i=0.
  - Both counters reset on start acceptance, clear_i or rst_ni, and saturate at all-ones.
- Undefined: both outputs tied to 0 and no counter flops are instantiated.

Test Plan:
- Full job: start with en_feat=1, en_weight=1, n_weight=3, en_norm=1, en_streamin=0, en_store=1; done/empty held high -> ld_which_sel sequence 0,1,1,1,3. Three src_req_start pulses while sel=1, STORE with ld_st_sel=1, done_o at cycle 24.
- Drain stall: FEAT only, fifo_empty_i low for 5 cycles after source_done -> clear_source_o delayed 5 cycles, sel unchanged throughout, perf_drain_cnt_o=5 with macro.
- Empty job: all enables 0 -> done_o 2 cycles after start, no start or clear pulses.
- n_weight_i=0 with en_weight=1 -> exactly one WEIGHT load.
- clear_i asserted in L_WAIT of the NORM phase -> next cycle IDLE, busy_o=0, sel=0. A new start_i is accepted the following cycle.
- Stale done: source_done_i held high during L_ISSUE only -> FSM stays in L_WAIT until a fresh done arrives.

Source files
------------

// File: rtl/neureka_streamer_sequencer.sv
// Phase sequencer for the NEUREKA streamer load/store path.
// Walks one job through FEAT, WEIGHT (repeated), NORM, STREAMIN and STORE,
// driving the TCDM mux selects, start pulses and clear pulses per phase.
// Optional performance counters: define NEUREKA_STREAMER_SEQ_PERF_EN.
// All outputs are registered and reflect the state held in the same cycle.
// Clear pulses fire in the cycle after the drain completes.
module neureka_streamer_sequencer #(
    parameter int unsigned WEIGHT_CNT_W = 8,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic                    en_feat_i,
    input  logic                    en_weight_i,
    input  logic [WEIGHT_CNT_W-1:0] n_weight_i,
    input  logic                    en_norm_i,
    input  logic                    en_streamin_i,
    input  logic                    en_store_i,
    input  logic                    source_done_i,
    input  logic                    sink_done_i,
    input  logic                    fifo_empty_i,
    output logic [2:0]              ld_which_sel_o,
    output logic                    ld_st_sel_o,
    output logic                    src_req_start_o,
    output logic                    sink_req_start_o,
    output logic                    clear_source_o,
    output logic                    clear_sink_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_W-1:0]        perf_busy_cnt_o,
    output logic [CNT_W-1:0]        perf_drain_cnt_o
);

    localparam int unsigned PH_W        = 5;
    localparam int unsigned SEL_W       = 3;
    localparam int unsigned PH_FEAT     = 0;
    localparam int unsigned PH_WEIGHT   = 1;
    localparam int unsigned PH_NORM     = 2;
    localparam int unsigned PH_STREAMIN = 3;
    localparam int unsigned PH_STORE    = 4;

    typedef enum logic [3:0] {
        IDLE,
        SELECT,
        L_ISSUE,
        L_WAIT,
        L_DRAIN,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        FINISH
    } state_e;

    state_e                  state_q, state_d;
    logic [PH_W-1:0]         rem_q, rem_d;     // phases still to run
    logic [PH_W-1:0]         cur_q, cur_d;     // one-hot active phase, 0 when none
    logic [WEIGHT_CNT_W-1:0] wcnt_q, wcnt_d;
    logic [SEL_W-1:0]        which_q, which_d;
    logic                    st_q, st_d;
    logic                    busy_q, busy_d;
    logic                    src_start_q, src_start_d;
    logic                    sink_start_q, sink_start_d;
    logic                    clr_src_q, clr_src_d;
    logic                    clr_sink_q, clr_sink_d;
    logic                    done_q, done_d;
    logic                    enter_sel;

    // Lowest set bit of the remaining mask is the next phase in job order.
    function automatic logic [PH_W-1:0] first_phase(input logic [PH_W-1:0] m);
        return m & (~m + PH_W'(1));
    endfunction

    // Load-select code of a one-hot phase; STORE and "none" map to 0.
    function automatic logic [SEL_W-1:0] sel_code(input logic [PH_W-1:0] oh);
        logic [SEL_W-1:0] c;
        c = SEL_W'(0);
        if (oh[PH_WEIGHT])        c = SEL_W'(1);
        else if (oh[PH_NORM])     c = SEL_W'(3);
        else if (oh[PH_STREAMIN]) c = SEL_W'(4);
        return c;
    endfunction

    // Next-state, phase bookkeeping and next output values.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        cur_d      = cur_q;
        wcnt_d     = wcnt_q;
        clr_src_d  = 1'b0;
        clr_sink_d = 1'b0;
        enter_sel  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    rem_d     = {en_store_i, en_streamin_i, en_norm_i, en_weight_i, en_feat_i};
                    wcnt_d    = (n_weight_i == '0) ? WEIGHT_CNT_W'(1) : n_weight_i;
                    state_d   = SELECT;
                    enter_sel = 1'b1;
                end
            end
            SELECT: begin
                if (cur_q == '0)          state_d = FINISH;
                else if (cur_q[PH_STORE]) state_d = S_ISSUE;
                else                      state_d = L_ISSUE;
            end
            L_ISSUE: state_d = L_WAIT;
            L_WAIT: begin
                if (source_done_i) state_d = L_DRAIN;
            end
            L_DRAIN: begin
                if (fifo_empty_i) begin
                    clr_src_d = 1'b1;
                    if (cur_q[PH_WEIGHT] && wcnt_q != '0) begin
                        wcnt_d = wcnt_q - WEIGHT_CNT_W'(1);
                    end
                    if (cur_q[PH_WEIGHT] && wcnt_d != '0) begin
                        state_d = L_ISSUE;
                    end else begin
                        rem_d     = rem_q & ~cur_q;
                        state_d   = SELECT;
                        enter_sel = 1'b1;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (sink_done_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_empty_i) begin
                    clr_sink_d = 1'b1;
                    rem_d      = rem_q & ~cur_q;
                    state_d    = SELECT;
                    enter_sel  = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (enter_sel) begin
            cur_d = first_phase(rem_d);
        end

        if (clear_i) begin
            state_d    = IDLE;
            rem_d      = '0;
            cur_d      = '0;
            wcnt_d     = '0;
            clr_src_d  = 1'b0;
            clr_sink_d = 1'b0;
        end

        which_d      = sel_code(cur_d);
        st_d         = cur_d[PH_STORE];
        busy_d       = (state_d != IDLE);
        src_start_d  = (state_d == L_ISSUE);
        sink_start_d = (state_d == S_ISSUE);
        done_d       = (state_d == FINISH);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            cur_q        <= '0;
            wcnt_q       <= '0;
            which_q      <= '0;
            st_q         <= 1'b0;
            busy_q       <= 1'b0;
            src_start_q  <= 1'b0;
            sink_start_q <= 1'b0;
            clr_src_q    <= 1'b0;
            clr_sink_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            cur_q        <= cur_d;
            wcnt_q       <= wcnt_d;
            which_q      <= which_d;
            st_q         <= st_d;
            busy_q       <= busy_d;
            src_start_q  <= src_start_d;
            sink_start_q <= sink_start_d;
            clr_src_q    <= clr_src_d;
            clr_sink_q   <= clr_sink_d;
            done_q       <= done_d;
        end
    end

    assign ld_which_sel_o   = which_q;
    assign ld_st_sel_o      = st_q;
    assign src_req_start_o  = src_start_q;
    assign sink_req_start_o = sink_start_q;
    assign clear_source_o   = clr_src_q;
    assign clear_sink_o     = clr_sink_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

`ifdef NEUREKA_STREAMER_SEQ_PERF_EN
    logic [CNT_W-1:0] busy_cnt_q;
    logic [CNT_W-1:0] drain_cnt_q;
    logic             cnt_rst;
    logic             drain_stall;

    assign cnt_rst     = clear_i | ((state_q == IDLE) & start_i);
    assign drain_stall = ((state_q == L_DRAIN) | (state_q == S_DRAIN)) & ~fifo_empty_i;

    // Saturating busy-cycle and drain-stall counters, restarted per job.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else if (cnt_rst) begin
            busy_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            if (busy_q && busy_cnt_q != '1) busy_cnt_q <= busy_cnt_q + CNT_W'(1);
            if (drain_stall && drain_cnt_q != '1) drain_cnt_q <= drain_cnt_q + CNT_W'(1);
        end
    end

    assign perf_busy_cnt_o  = busy_cnt_q;
    assign perf_drain_cnt_o = drain_cnt_q;
`else
    assign perf_busy_cnt_o  = '0;
    assign perf_drain_cnt_o = '0;
`endif

endmodule

// File: tb/tb_neureka_streamer_sequencer.sv
// Self-checking bench for neureka_streamer_sequencer: a phase-list model
// predicts every output each cycle, plus literal timing/count checks per job.
module tb_neureka_streamer_sequencer;

    localparam int unsigned WEIGHT_CNT_W = 8;
    localparam int unsigned CNT_W        = 32;
    localparam longint      CNT_MAX      = (64'd1 << CNT_W) - 1;

    logic                    clk;
    logic                    rst_n;
    logic                    clear_i;
    logic                    start_i;
    logic                    en_feat_i, en_weight_i, en_norm_i, en_streamin_i, en_store_i;
    logic [WEIGHT_CNT_W-1:0] n_weight_i;
    logic                    source_done_i, sink_done_i, fifo_empty_i;
    logic [2:0]              ld_which_sel_o;
    logic                    ld_st_sel_o;
    logic                    src_req_start_o, sink_req_start_o;
    logic                    clear_source_o, clear_sink_o;
    logic                    busy_o, done_o;
    logic [CNT_W-1:0]        perf_busy_cnt_o, perf_drain_cnt_o;

    neureka_streamer_sequencer #(
        .WEIGHT_CNT_W(WEIGHT_CNT_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .clear_i         (clear_i),
        .start_i         (start_i),
        .en_feat_i       (en_feat_i),
        .en_weight_i     (en_weight_i),
        .n_weight_i      (n_weight_i),
        .en_norm_i       (en_norm_i),
        .en_streamin_i   (en_streamin_i),
        .en_store_i      (en_store_i),
        .source_done_i   (source_done_i),
        .sink_done_i     (sink_done_i),
        .fifo_empty_i    (fifo_empty_i),
        .ld_which_sel_o  (ld_which_sel_o),
        .ld_st_sel_o     (ld_st_sel_o),
        .src_req_start_o (src_req_start_o),
        .sink_req_start_o(sink_req_start_o),
        .clear_source_o  (clear_source_o),
        .clear_sink_o    (clear_sink_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .perf_busy_cnt_o (perf_busy_cnt_o),
        .perf_drain_cnt_o(perf_drain_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model: job = list of phases ----------------
    typedef struct {
        int code;
        bit store;
        int reps;
    } ph_t;

    localparam int M_IDLE = 0, M_SEL = 1, M_LISS = 2, M_LWT = 3, M_LDRN = 4,
                   M_SISS = 5, M_SWT = 6, M_SDRN = 7, M_FIN = 8;

    ph_t    m_q[$];
    ph_t    m_cur;
    bit     m_have   = 0;
    int     m_stage  = M_IDLE;
    int     m_reps   = 0;
    int     e_which  = 0;
    bit     e_st     = 0;
    bit     e_clrsrc = 0;
    bit     e_clrsink = 0;
    longint e_bcnt   = 0;
    longint e_dcnt   = 0;

    task automatic m_next_phase();
        if (m_q.size() > 0) begin
            m_cur   = m_q.pop_front();
            m_have  = 1;
            m_reps  = m_cur.reps;
            e_which = m_cur.store ? 0 : m_cur.code;
            e_st    = m_cur.store;
        end else begin
            m_have  = 0;
            e_which = 0;
            e_st    = 0;
        end
        m_stage = M_SEL;
    endtask

    task automatic m_step();
        bit was_busy, stall, accepted;
        ph_t p;
        if (!rst_n) begin
            m_q.delete(); m_have = 0; m_stage = M_IDLE; e_which = 0; e_st = 0;
            e_clrsrc = 0; e_clrsink = 0; e_bcnt = 0; e_dcnt = 0;
            return;
        end
        was_busy  = (m_stage != M_IDLE);
        stall     = (m_stage == M_LDRN || m_stage == M_SDRN) && !fifo_empty_i;
        accepted  = (m_stage == M_IDLE) && start_i;
        e_clrsrc  = 0;
        e_clrsink = 0;
        if (clear_i) begin
            m_q.delete(); m_have = 0; m_stage = M_IDLE; e_which = 0; e_st = 0;
            e_bcnt = 0; e_dcnt = 0;
            return;
        end
        case (m_stage)
            M_IDLE: if (start_i) begin
                m_q.delete();
                if (en_feat_i)     begin p.code = 0; p.store = 0; p.reps = 1; m_q.push_back(p); end
                if (en_weight_i)   begin p.code = 1; p.store = 0;
                                         p.reps = (n_weight_i == 0) ? 1 : int'(n_weight_i);
                                         m_q.push_back(p); end
                if (en_norm_i)     begin p.code = 3; p.store = 0; p.reps = 1; m_q.push_back(p); end
                if (en_streamin_i) begin p.code = 4; p.store = 0; p.reps = 1; m_q.push_back(p); end
                if (en_store_i)    begin p.code = 0; p.store = 1; p.reps = 1; m_q.push_back(p); end
                m_next_phase();
            end
            M_SEL:  m_stage = !m_have ? M_FIN : (m_cur.store ? M_SISS : M_LISS);
            M_LISS: m_stage = M_LWT;
            M_LWT:  if (source_done_i) m_stage = M_LDRN;
            M_LDRN: if (fifo_empty_i) begin
                e_clrsrc = 1;
                m_reps--;
                if (m_reps > 0) m_stage = M_LISS;
                else            m_next_phase();
            end
            M_SISS: m_stage = M_SWT;
            M_SWT:  if (sink_done_i) m_stage = M_SDRN;
            M_SDRN: if (fifo_empty_i) begin
                e_clrsink = 1;
                m_next_phase();
            end
            M_FIN:  begin m_stage = M_IDLE; e_which = 0; e_st = 0; end
            default: m_stage = M_IDLE;
        endcase
        if (accepted) begin
            e_bcnt = 0;
            e_dcnt = 0;
        end else begin
            if (was_busy && e_bcnt < CNT_MAX) e_bcnt++;
            if (stall && e_dcnt < CNT_MAX)    e_dcnt++;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        m_step();
    end

    // ---------------- per-job observation record ----------------
    int t0 = 0;
    bit done_seen = 0;
    int done_cyc = -1;
    int src_n = 0, sink_n = 0, clrsrc_n = 0, clrsink_n = 0;
    int clrsrc_cyc = -1;
    bit sink_st = 0;
    int src_sel[$];

    task automatic mon_clear();
        done_seen = 0; done_cyc = -1; src_n = 0; sink_n = 0;
        clrsrc_n = 0; clrsink_n = 0; clrsrc_cyc = -1; sink_st = 0;
        src_sel.delete();
    endtask

    // Compare every output to the model and log events, on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            chk("ld_which_sel", 64'(ld_which_sel_o), 64'(e_which));
            chk("ld_st_sel", 64'(ld_st_sel_o), 64'(e_st));
            chk("busy", 64'(busy_o), 64'(m_stage != M_IDLE));
            chk("src_req_start", 64'(src_req_start_o), 64'(m_stage == M_LISS));
            chk("sink_req_start", 64'(sink_req_start_o), 64'(m_stage == M_SISS));
            chk("clear_source", 64'(clear_source_o), 64'(e_clrsrc));
            chk("clear_sink", 64'(clear_sink_o), 64'(e_clrsink));
            chk("done", 64'(done_o), 64'(m_stage == M_FIN));
`ifdef NEUREKA_STREAMER_SEQ_PERF_EN
            chk("perf_busy", 64'(perf_busy_cnt_o), 64'(e_bcnt));
            chk("perf_drain", 64'(perf_drain_cnt_o), 64'(e_dcnt));
`else
            chk("perf_busy_tied", 64'(perf_busy_cnt_o), 64'd0);
            chk("perf_drain_tied", 64'(perf_drain_cnt_o), 64'd0);
`endif
            if (done_o && !done_seen) begin done_seen = 1; done_cyc = cyc - t0; end
            if (src_req_start_o) begin src_n++; src_sel.push_back(int'(ld_which_sel_o)); end
            if (sink_req_start_o) begin sink_n++; sink_st = ld_st_sel_o; end
            if (clear_source_o) begin clrsrc_n++; clrsrc_cyc = cyc - t0; end
            if (clear_sink_o) clrsink_n++;
        end
    end

    // ---------------- stimulus helpers (called just after a rising edge) ----------------
    task automatic drive_idle();
        clear_i = 0; start_i = 0;
        source_done_i = 1; sink_done_i = 1; fifo_empty_i = 1;
    endtask

    task automatic start_job(input bit f, input bit w, input int n, input bit no,
                             input bit si, input bit st);
        en_feat_i = f; en_weight_i = w; n_weight_i = WEIGHT_CNT_W'(n);
        en_norm_i = no; en_streamin_i = si; en_store_i = st;
        start_i = 1;
        t0 = cyc;
        mon_clear();
        @(posedge clk); #1;
        start_i = 0;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (!done_seen && k < budget) begin @(posedge clk); k++; end
        #1;
        chk(name, 64'(done_seen), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        drive_idle();
        en_feat_i = 0; en_weight_i = 0; en_norm_i = 0; en_streamin_i = 0; en_store_i = 0;
        n_weight_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_which", 64'(ld_which_sel_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_pulses", 64'({src_req_start_o, sink_req_start_o, clear_source_o,
                               clear_sink_o, done_o, ld_st_sel_o}), 64'd0);
        chk("rst_perf", 64'(perf_busy_cnt_o | perf_drain_cnt_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (2) begin @(posedge clk); #1; end

        // Full job: FEAT, WEIGHT x3, NORM, STORE with done/empty high.
        start_job(1, 1, 3, 1, 0, 1);
        wait_done("full_done_seen", 100);
        chk("full_done_cyc", 64'(done_cyc), 64'd24);
        chk("full_src_n", 64'(src_n), 64'd5);
        if (src_sel.size() == 5) begin
            chk("full_sel0", 64'(src_sel[0]), 64'd0);
            chk("full_sel1", 64'(src_sel[1]), 64'd1);
            chk("full_sel3", 64'(src_sel[3]), 64'd1);
            chk("full_sel4", 64'(src_sel[4]), 64'd3);
        end
        chk("full_sink_n", 64'(sink_n), 64'd1);
        chk("full_sink_st", 64'(sink_st), 64'd1);
        chk("full_clrsrc_n", 64'(clrsrc_n), 64'd5);
        chk("full_clrsink_n", 64'(clrsink_n), 64'd1);
        repeat (2) begin @(posedge clk); #1; end

        // Drain stall: FEAT only, FIFO not empty for 5 drain cycles.
        start_job(1, 0, 0, 0, 0, 0);
        fifo_empty_i = 0;
        goto_cyc(t0 + 9);
        fifo_empty_i = 1;
        wait_done("stall_done_seen", 100);
        chk("stall_clrsrc_cyc", 64'(clrsrc_cyc), 64'd10);
        chk("stall_done_cyc", 64'(done_cyc), 64'd11);
`ifdef NEUREKA_STREAMER_SEQ_PERF_EN
        chk("stall_perf_drain", 64'(perf_drain_cnt_o), 64'd5);
        chk("stall_perf_busy", 64'(perf_busy_cnt_o), 64'd11);
`endif
        repeat (2) begin @(posedge clk); #1; end

        // n_weight = 0 gives a single WEIGHT load.
        start_job(0, 1, 0, 0, 0, 0);
        wait_done("nw0_done_seen", 100);
        chk("nw0_src_n", 64'(src_n), 64'd1);
        chk("nw0_done_cyc", 64'(done_cyc), 64'd6);
        repeat (2) begin @(posedge clk); #1; end

        // Stale done: high only in the ISSUE cycle, fresh done arrives later.
        source_done_i = 0;
        start_job(1, 0, 0, 0, 0, 0);
        goto_cyc(t0 + 2); source_done_i = 1;
        goto_cyc(t0 + 3); source_done_i = 0;
        goto_cyc(t0 + 6); source_done_i = 1;
        wait_done("stale_done_seen", 100);
        chk("stale_clrsrc_cyc", 64'(clrsrc_cyc), 64'd8);
        chk("stale_done_cyc", 64'(done_cyc), 64'd9);
        repeat (2) begin @(posedge clk); #1; end

        // Clear during the NORM wait, then an empty job right after.
        start_job(1, 0, 0, 1, 0, 0);
        goto_cyc(t0 + 4); source_done_i = 0;
        goto_cyc(t0 + 8); clear_i = 1;
        @(negedge clk);
        chk("clr_pre_sel", 64'(ld_which_sel_o), 64'd3);
        chk("clr_pre_busy", 64'(busy_o), 64'd1);
        @(posedge clk); #1;
        clear_i = 0;
        source_done_i = 1;
        en_feat_i = 0; en_weight_i = 0; en_norm_i = 0; en_streamin_i = 0; en_store_i = 0;
        start_i = 1;
        t0 = cyc;
        mon_clear();
        @(negedge clk);
        chk("clr_post_busy", 64'(busy_o), 64'd0);
        chk("clr_post_sel", 64'(ld_which_sel_o), 64'd0);
        @(posedge clk); #1;
        start_i = 0;
        wait_done("empty_done_seen", 50);
        chk("empty_done_cyc", 64'(done_cyc), 64'd2);
        chk("empty_pulses", 64'(src_n + sink_n + clrsrc_n + clrsink_n), 64'd0);
        repeat (2) begin @(posedge clk); #1; end

        // Maximum weight count.
        start_job(0, 1, 255, 0, 0, 0);
        wait_done("nwmax_done_seen", 1000);
        chk("nwmax_src_n", 64'(src_n), 64'd255);
        chk("nwmax_done_cyc", 64'(done_cyc), 64'd768);
        repeat (2) begin @(posedge clk); #1; end

        // All phases with irregular done/empty handshakes.
        start_job(1, 1, 2, 1, 1, 1);
        begin
            int k = 0;
            while (!done_seen && k < 3000) begin
                @(posedge clk); #1;
                source_done_i = 1'($urandom_range(0, 1));
                sink_done_i   = 1'($urandom_range(0, 1));
                fifo_empty_i  = 1'($urandom_range(0, 1));
                k++;
            end
        end
        chk("rand_done_seen", 64'(done_seen), 64'd1);
        chk("rand_src_n", 64'(src_n), 64'd5);
        chk("rand_sink_n", 64'(sink_n), 64'd1);
        drive_idle();
        repeat (3) begin @(posedge clk); #1; end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
